// File: rtl/pe_act_receiver.sv
// Receive end of the PE activation broadcast path.
// Buffers router flits in a 2-entry FIFO, pushes non-zero activations into the
// PE activation queue, and tracks per-source FIN tokens to signal the end of a layer.
//
// state | meaning
// IDLE  | waiting for pe_start_calc; no flits accepted
// RECV  | accepting flits and draining the head one per cycle
// DONE  | every source has finished; fin_broadcast pulses for this one cycle
module pe_act_receiver #(
    parameter int PE_IDX     = 0,
    parameter int NUM_PE     = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int IDX_WIDTH  = 11,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pe_start_calc,
    input  logic                          rx_valid,
    input  logic                          rx_type,
    input  logic [ADDR_WIDTH-1:0]         rx_src,
    input  logic [IDX_WIDTH-1:0]          rx_idx,
    input  logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          rx_rdy,
    input  logic                          queue_full,
    output logic                          push_act,
    output logic [IDX_WIDTH+DATA_WIDTH-1:0] act_in,
    output logic                          fin_broadcast,
    output logic                          rx_err
);

    localparam int SRC_SPACE = 1 << ADDR_WIDTH;
    localparam int ACT_W     = IDX_WIDTH + DATA_WIDTH;
    localparam int ENTRY_W   = 1 + ADDR_WIDTH + ACT_W;
    localparam logic [ADDR_WIDTH:0] NUM_PE_EXT = (ADDR_WIDTH + 1)'(NUM_PE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ENTRY_W-1:0]     fifo_mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    logic [NUM_PE-1:0]      bitmap;
    logic [NUM_PE-1:0]      bitmap_next;
    logic [SRC_SPACE-1:0]   bitmap_ext;
    logic [ACT_W-1:0]       act_last;

    logic [ENTRY_W-1:0]     head;
    logic                   head_type;
    logic [ADDR_WIDTH-1:0]  head_src;
    logic [IDX_WIDTH-1:0]   head_idx;
    logic [DATA_WIDTH-1:0]  head_data;
    logic                   head_valid;
    logic                   head_bad;
    logic                   accept;
    logic                   pop;
    logic                   err_hit;
    logic                   fin_hit;

    assign head      = fifo_mem[rd_ptr];
    assign head_type = head[ENTRY_W-1];
    assign head_src  = head[ENTRY_W-2 -: ADDR_WIDTH];
    assign head_idx  = head[DATA_WIDTH +: IDX_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];

    // Widened copy lets any representable src index the bitmap; out-of-range bits read 0.
    assign bitmap_ext = SRC_SPACE'(bitmap);
    assign head_valid = (state == RECV) && (count != 2'd0);
    assign head_bad   = ({1'b0, head_src} >= NUM_PE_EXT) || bitmap_ext[head_src];

    // Ready depends only on registered state so the router never sees a loop through rx_valid.
    assign rx_rdy = (state == RECV) && (count != 2'd2);
    assign accept = rx_valid && rx_rdy;

    assign fin_broadcast = (state == DONE);
    assign act_in        = push_act ? {head_idx, head_data} : act_last;

    // Head decode: decide whether the head pops, pushes, flags an error or records a FIN.
    always_comb begin
        push_act = 1'b0;
        pop      = 1'b0;
        err_hit  = 1'b0;
        fin_hit  = 1'b0;
        if (head_valid) begin
            if (head_bad) begin
                pop     = 1'b1;
                err_hit = 1'b1;
            end else if (head_type) begin
                pop     = 1'b1;
                fin_hit = 1'b1;
            end else if (head_data == '0) begin
                pop = 1'b1;
            end else if (!queue_full) begin
                pop      = 1'b1;
                push_act = 1'b1;
            end
        end
    end

    // Next FIN bitmap: cleared when a layer is armed, one bit added per good FIN.
    always_comb begin
        bitmap_next = bitmap;
        if ((state == IDLE) && pe_start_calc) begin
            bitmap_next = '0;
        end else if (fin_hit) begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (head_src == ADDR_WIDTH'(i)) begin
                    bitmap_next[i] = 1'b1;
                end
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (pe_start_calc) state_next = RECV;
            RECV: if (fin_hit && (&bitmap_next)) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, FIFO pointers, bitmap, error flag and last pushed entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            bitmap   <= '0;
            rx_err   <= 1'b0;
            act_last <= '0;
        end else begin
            state  <= state_next;
            bitmap <= bitmap_next;
            if (accept) wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (err_hit)  rx_err   <= 1'b1;
            if (push_act) act_last <= {head_idx, head_data};
        end
    end

    // FIFO storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= {rx_type, rx_src, rx_idx, rx_data};
    end

    // A push into a full queue would lose an activation.
    assert property (@(posedge clk) disable iff (!rst) !(push_act && queue_full))
        else $error("pe_act_receiver[%0d]: push while queue full", PE_IDX);

endmodule
